router_modport: RTL and testbench
=================================

ROUTER_MODPORT -- requirements
Module: router_modport

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, words per destination FIFO (power of two).
REQ-002 Parameter SOFT_RST_CYCLES, default 30, idle-read timeout per destination.
REQ-003 Clocking: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock, all logic on posedge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 pkt_vld  input  1  source byte on din valid.
REQ-007 din  input  8  source packet byte.
REQ-008 busy  output  1  source must hold din/pkt_vld this cycle.
REQ-009 err  output  1  one-cycle parity-error pulse.
REQ-010 read_enb_0..2  input  1 each  destination k read request.
REQ-011 vld_out_0..2  output  1 each  FIFO k non-empty.
REQ-012 dout_0..2  output  8 each  destination k read data.

Function
REQ-013 Packet = header, LEN payload bytes, parity byte; header[1:0] = destination (0..2), header[7:2] = LEN (1..63).
REQ-014 Byte accepted on posedge with pkt_vld=1 and busy=0; source holds byte while busy=1.
REQ-015 FSM states: DECODE, WAIT_EMPTY, LOAD_DATA, CHECK_PARITY.
REQ-016 DECODE: busy=0; accepted header with addr 3 dropped, stay DECODE; addr k with FIFO k empty: header written to FIFO k, -> LOAD_DATA; FIFO k non-empty: header latched internally, -> WAIT_EMPTY.
REQ-017 WAIT_EMPTY: busy=1; when FIFO k empty, latched header written, -> LOAD_DATA.
REQ-018 LOAD_DATA: busy = full_k; each accepted byte written to FIFO k; byte counter counts LEN payloads plus parity; after parity byte written -> CHECK_PARITY.
REQ-019 CHECK_PARITY: busy=1 for one cycle; computed parity = XOR of header and all payloads; err=1 on next cycle for exactly one cycle if computed != received parity; -> DECODE.
REQ-020 Header, payloads, parity all stored in FIFO k and read out in arrival order.
REQ-021 Destination FIFO: FIFO_DEPTH x 8, separate read/write pointers plus occupancy count; full when count=FIFO_DEPTH, empty when 0; pointers wrap modulo depth.
REQ-022 Read: read_enb_k=1 and FIFO k non-empty pops one word; dout_k updated registered on same edge (valid cycle after request); read when empty ignored, dout_k holds.
REQ-023 Simultaneous read and write same FIFO in one cycle: both performed, count unchanged; write allowed when full only if same-cycle read.
REQ-024 vld_out_k = FIFO k non-empty (combinational from count).
REQ-025 Soft reset: counter k increments each cycle vld_out_k=1 and read_enb_k=0, clears otherwise; reaching SOFT_RST_CYCLES flushes FIFO k (count/pointers 0) next edge, counter cleared.
REQ-026 Soft reset of FIFO currently targeted by FSM aborts packet: FSM -> DECODE, no err, remaining source bytes until pkt_vld=0 discarded (busy=0).

Reset
REQ-027 rst=0 on posedge: FSM DECODE, all FIFOs empty, counters 0, busy=0, err=0, vld_out_k=0, dout_k=8'h00.
REQ-028 Reset mid-packet discards partial packet and all FIFO content.

Structure
REQ-029 Shared package holds FSM state enum, address width (2), LEN field width (6) and default depth/timeout constants.
REQ-030 One sub-module router_fifo (depth, full/empty, soft-reset flush) instantiated three times; FSM, parity and routing in top.

Verification
REQ-031 Header 8'h0C (addr 0, LEN 3), payloads 11,22,33, parity 8'h0C^11^22^33 -> FIFO 0 holds 5 bytes, vld_out_0=1, err stays 0, read back in order.
REQ-032 Same packet with parity 8'hFF -> err=1 one cycle after CHECK_PARITY, data still stored.
REQ-033 Header addr 1 LEN 20 with read_enb_1=0 -> busy=1 when FIFO 1 reaches 16 words; reading resumes accept, no byte lost or duplicated.
REQ-034 Second packet to non-empty FIFO 2 -> busy=1 in WAIT_EMPTY until FIFO 2 drained.
REQ-035 FIFO 0 non-empty, read_enb_0=0 for 30 cycles -> vld_out_0=0 on next cycle.
REQ-036 rst=0 mid-payload -> busy=0, err=0, all vld_out=0, dout=0 next cycle.

Source files
------------

// File: rtl/router_modport_pkg.sv
// Shared types and constants for the three-port packet router.
package router_modport_pkg;

  localparam int ADDR_W              = 2;
  localparam int LEN_W               = 6;
  localparam int NUM_DEST            = 3;
  localparam int DEF_FIFO_DEPTH      = 16;
  localparam int DEF_SOFT_RST_CYCLES = 30;

  typedef enum logic [1:0] {
    DECODE       = 2'd0,
    WAIT_EMPTY   = 2'd1,
    LOAD_DATA    = 2'd2,
    CHECK_PARITY = 2'd3
  } state_t;

  // Destination field of a header byte
  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] h);
    return h[ADDR_W-1:0];
  endfunction

  // Payload length field of a header byte
  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] h);
    return h[7:ADDR_W];
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-destination byte FIFO with occupancy count, registered read data and an
// idle-read timeout that flushes the contents.
module router_fifo
  import router_modport_pkg::*;
#(
  parameter int DEPTH           = DEF_FIFO_DEPTH,
  parameter int SOFT_RST_CYCLES = DEF_SOFT_RST_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_data,
  input  logic       i_rd_en,
  output logic [7:0] o_rd_data,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_flush
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(SOFT_RST_CYCLES + 1);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [TMO_W-1:0] r_idle_cnt;
  logic [7:0]       r_rd_data;

  logic w_do_rd;
  logic w_do_wr;
  logic w_idle;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_rd   = i_rd_en && !o_empty;
  // A full FIFO still takes a write when a word leaves on the same edge
  assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
  assign w_idle    = !o_empty && !i_rd_en;
  // Last idle cycle before timeout: contents are dropped on this edge
  assign o_flush   = w_idle && (r_idle_cnt == TMO_W'(SOFT_RST_CYCLES - 1));
  assign o_rd_data = r_rd_data;

  // Storage array, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Registered read port; holds its value when nothing is popped
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data <= 8'h00;
    end else if (w_do_rd) begin
      r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  // Pointers, occupancy and idle timeout
  always_ff @(posedge clk) begin
    if (!rst || o_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_idle_cnt <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_idle_cnt <= w_idle ? r_idle_cnt + TMO_W'(1) : '0;
    end
  end

endmodule

// File: rtl/router_modport.sv
// Packet router: decodes header, steers bytes into one of three FIFOs,
// checks XOR parity and throttles the source through busy.
module router_modport
  import router_modport_pkg::*;
#(
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int SOFT_RST_CYCLES = DEF_SOFT_RST_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_vld,
  input  logic [7:0] din,
  output logic       busy,
  output logic       err,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic [7:0] dout_0,
  output logic [7:0] dout_1,
  output logic [7:0] dout_2
);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_header;
  logic [7:0]         r_parity;
  logic [7:0]         r_rx_parity;
  logic [LEN_W:0]     r_remaining;
  logic               r_err;
  logic               r_discard;

  logic [NUM_DEST-1:0] w_rd_en;
  logic [NUM_DEST-1:0] w_wr_en;
  logic [NUM_DEST-1:0] w_full;
  logic [NUM_DEST-1:0] w_empty;
  logic [NUM_DEST-1:0] w_flush;
  logic [7:0]          w_dout [NUM_DEST];
  logic [7:0]          w_wr_data;
  logic [ADDR_W-1:0]   w_din_addr;
  logic                w_din_empty;
  logic                w_tgt_full;
  logic                w_tgt_empty;
  logic                w_tgt_flush;
  logic                w_accept;

  assign w_rd_en    = {read_enb_2, read_enb_1, read_enb_0};
  assign vld_out_0  = !w_empty[0];
  assign vld_out_1  = !w_empty[1];
  assign vld_out_2  = !w_empty[2];
  assign dout_0     = w_dout[0];
  assign dout_1     = w_dout[1];
  assign dout_2     = w_dout[2];
  assign err        = r_err;
  assign w_din_addr = hdr_addr(din);
  assign w_accept   = pkt_vld && !busy;

  generate
    for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_fifo
      router_fifo #(
        .DEPTH           (FIFO_DEPTH),
        .SOFT_RST_CYCLES (SOFT_RST_CYCLES)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en[gi]),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en[gi]),
        .o_rd_data (w_dout[gi]),
        .o_full    (w_full[gi]),
        .o_empty   (w_empty[gi]),
        .o_flush   (w_flush[gi])
      );
    end
  endgenerate

  // Status of the FIFO addressed by the incoming byte and by the latched header
  always_comb begin
    w_din_empty = 1'b0;
    w_tgt_full  = 1'b0;
    w_tgt_empty = 1'b0;
    w_tgt_flush = 1'b0;
    for (int k = 0; k < NUM_DEST; k++) begin
      if (w_din_addr == ADDR_W'(k)) w_din_empty = w_empty[k];
      if (r_addr == ADDR_W'(k)) begin
        w_tgt_full  = w_full[k];
        w_tgt_empty = w_empty[k];
        w_tgt_flush = w_flush[k];
      end
    end
  end

  // Source back-pressure from the current state
  always_comb begin
    case (r_state)
      DECODE:       busy = 1'b0;
      WAIT_EMPTY:   busy = 1'b1;
      LOAD_DATA:    busy = w_tgt_full;
      default:      busy = 1'b1;
    endcase
  end

  // Route header/payload/parity writes to the selected FIFO
  always_comb begin
    w_wr_en   = '0;
    w_wr_data = din;
    for (int k = 0; k < NUM_DEST; k++) begin
      case (r_state)
        DECODE:
          if (w_accept && !r_discard && w_din_empty && w_din_addr == ADDR_W'(k))
            w_wr_en[k] = 1'b1;
        WAIT_EMPTY:
          if (w_tgt_empty && r_addr == ADDR_W'(k)) begin
            w_wr_en[k] = 1'b1;
            w_wr_data  = r_header;
          end
        LOAD_DATA:
          if (w_accept && r_addr == ADDR_W'(k))
            w_wr_en[k] = 1'b1;
        default: ;
      endcase
    end
  end

  // Packet FSM with parity accumulation and registered error pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= DECODE;
      r_addr      <= '0;
      r_header    <= 8'h00;
      r_parity    <= 8'h00;
      r_rx_parity <= 8'h00;
      r_remaining <= '0;
      r_err       <= 1'b0;
      r_discard   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state != DECODE && w_tgt_flush) begin
        // Target FIFO timed out: drop the packet and swallow its tail
        r_state   <= DECODE;
        r_discard <= 1'b1;
      end else begin
        case (r_state)
          DECODE: begin
            if (r_discard) begin
              if (!pkt_vld) r_discard <= 1'b0;
            end else if (w_accept && w_din_addr != {ADDR_W{1'b1}}) begin
              r_addr      <= w_din_addr;
              r_header    <= din;
              r_parity    <= din;
              r_remaining <= {1'b0, hdr_len(din)} + (LEN_W+1)'(1);
              r_state     <= w_din_empty ? LOAD_DATA : WAIT_EMPTY;
            end
          end
          WAIT_EMPTY: begin
            if (w_tgt_empty) r_state <= LOAD_DATA;
          end
          LOAD_DATA: begin
            if (w_accept) begin
              r_remaining <= r_remaining - (LEN_W+1)'(1);
              if (r_remaining == (LEN_W+1)'(1)) begin
                r_rx_parity <= din;
                r_state     <= CHECK_PARITY;
              end else begin
                r_parity <= r_parity ^ din;
              end
            end
          end
          default: begin
            r_err   <= (r_parity != r_rx_parity);
            r_state <= DECODE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_modport.sv
// Directed self-checking bench for router_modport.
module tb_router_modport;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_vld;
  logic [7:0] din;
  logic       busy;
  logic       err;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [7:0] dout_0, dout_1, dout_2;

  int checks   = 0;
  int failures = 0;

  router_modport dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_vld    (pkt_vld),
    .din        (din),
    .busy       (busy),
    .err        (err),
    .read_enb_0 (read_enb_0),
    .read_enb_1 (read_enb_1),
    .read_enb_2 (read_enb_2),
    .vld_out_0  (vld_out_0),
    .vld_out_1  (vld_out_1),
    .vld_out_2  (vld_out_2),
    .dout_0     (dout_0),
    .dout_1     (dout_1),
    .dout_2     (dout_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one byte and hold it until the router accepts it
  task automatic send_byte(input logic [7:0] b);
    int guard;
    din     = b;
    pkt_vld = 1'b1;
    guard   = 0;
    while (busy === 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("send_wait_busy", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  logic [7:0] pkt [22];
  logic [7:0] par;
  logic [7:0] exp5 [5];
  int src, pop;
  logic busy_s, vld_s, err_seen;

  initial begin
    rst = 1'b0; pkt_vld = 1'b0; din = 8'h00;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    repeat (2) step();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_vld0", 32'(vld_out_0), 32'd0);
    check("rst_vld1", 32'(vld_out_1), 32'd0);
    check("rst_vld2", 32'(vld_out_2), 32'd0);
    check("rst_dout0", 32'(dout_0), 32'h00);
    rst = 1'b1;
    step();

    // Good packet to FIFO 0
    exp5[0] = 8'h0C; exp5[1] = 8'h11; exp5[2] = 8'h22; exp5[3] = 8'h33; exp5[4] = 8'h0C;
    for (int i = 0; i < 5; i++) send_byte(exp5[i]);
    pkt_vld = 1'b0;
    check("good_chkpar_busy", 32'(busy), 32'd1);
    step();
    check("good_err", 32'(err), 32'd0);
    check("good_vld0", 32'(vld_out_0), 32'd1);
    read_enb_0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("good_dout0", 32'(dout_0), 32'(exp5[i]));
    end
    check("good_drained_vld0", 32'(vld_out_0), 32'd0);
    step();
    check("empty_read_holds", 32'(dout_0), 32'h0C);
    read_enb_0 = 1'b0;
    $display("tx good packet dest0 len3");

    // Bad parity packet
    exp5[4] = 8'hFF;
    for (int i = 0; i < 5; i++) send_byte(exp5[i]);
    pkt_vld = 1'b0;
    check("bad_chkpar_busy", 32'(busy), 32'd1);
    check("bad_err_early", 32'(err), 32'd0);
    step();
    check("bad_err_pulse", 32'(err), 32'd1);
    step();
    check("bad_err_clear", 32'(err), 32'd0);
    check("bad_vld0", 32'(vld_out_0), 32'd1);
    read_enb_0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bad_dout0", 32'(dout_0), 32'(exp5[i]));
    end
    read_enb_0 = 1'b0;
    $display("tx bad-parity packet dest0 len3");

    // Long packet to FIFO 1 filling it
    pkt[0] = 8'h51;
    par = pkt[0];
    for (int i = 1; i <= 20; i++) begin
      pkt[i] = 8'(8'h40 + i);
      par = par ^ pkt[i];
    end
    pkt[21] = par;
    for (int i = 0; i < 16; i++) send_byte(pkt[i]);
    din = pkt[16];
    check("full_busy", 32'(busy), 32'd1);
    check("full_vld1", 32'(vld_out_1), 32'd1);
    src = 16; pop = 0; err_seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !(src == 22 && pop == 22); cyc++) begin
      if (src < 22) begin
        din = pkt[src];
        pkt_vld = 1'b1;
      end else begin
        pkt_vld = 1'b0;
      end
      read_enb_1 = 1'b1;
      busy_s = busy;
      vld_s  = vld_out_1;
      step();
      if (pkt_vld && !busy_s) src++;
      if (vld_s && pop < 22) begin
        check("long_dout1", 32'(dout_1), 32'(pkt[pop]));
        pop++;
      end
      if (err) err_seen = 1'b1;
    end
    pkt_vld = 1'b0;
    read_enb_1 = 1'b0;
    check("long_sent", 32'(src), 32'd22);
    check("long_popped", 32'(pop), 32'd22);
    check("long_no_err", 32'(err_seen), 32'd0);
    $display("tx long packet dest1 len20 bytes_out=%0d", pop);

    // Second packet waits for FIFO 2 to drain
    send_byte(8'h06); send_byte(8'hA5); send_byte(8'hA3);
    pkt_vld = 1'b0;
    step();
    send_byte(8'h06);
    pkt_vld = 1'b0;
    check("wait_busy", 32'(busy), 32'd1);
    repeat (3) step();
    check("wait_busy_hold", 32'(busy), 32'd1);
    exp5[0] = 8'h06; exp5[1] = 8'hA5; exp5[2] = 8'hA3;
    read_enb_2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_drain_dout2", 32'(dout_2), 32'(exp5[i]));
    end
    read_enb_2 = 1'b0;
    step();
    check("wait_released_busy", 32'(busy), 32'd0);
    check("wait_hdr_vld2", 32'(vld_out_2), 32'd1);
    send_byte(8'h5A); send_byte(8'h5C);
    pkt_vld = 1'b0;
    step();
    check("wait_err", 32'(err), 32'd0);
    exp5[0] = 8'h06; exp5[1] = 8'h5A; exp5[2] = 8'h5C;
    read_enb_2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_pkt2_dout2", 32'(dout_2), 32'(exp5[i]));
    end
    read_enb_2 = 1'b0;
    $display("tx queued packet dest2 after drain");

    // Idle-read timeout flushes FIFO 0
    send_byte(8'h04); send_byte(8'h77); send_byte(8'h73);
    pkt_vld = 1'b0;
    repeat (27) step();
    check("tmo_vld0_before", 32'(vld_out_0), 32'd1);
    step();
    check("tmo_vld0_flushed", 32'(vld_out_0), 32'd0);
    check("tmo_err", 32'(err), 32'd0);
    $display("tx timeout flush dest0");

    // Reset in the middle of a payload
    send_byte(8'h0D); send_byte(8'h01);
    check("mid_vld1", 32'(vld_out_1), 32'd1);
    din = 8'h02; pkt_vld = 1'b1; rst = 1'b0;
    step();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_vld", 32'({vld_out_2, vld_out_1, vld_out_0}), 32'd0);
    check("mid_rst_dout0", 32'(dout_0), 32'h00);
    check("mid_rst_dout1", 32'(dout_1), 32'h00);
    check("mid_rst_dout2", 32'(dout_2), 32'h00);
    rst = 1'b1; pkt_vld = 1'b0;
    step();
    $display("tx reset mid-payload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
